// File: rtl/swg_pkg.sv
// Shared types and helpers for the SWG loop address generator.
// Holds the controller state encoding, the address-width helper and the
// index helper used to slice the packed per-level configuration vectors.
package swg_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  // Address width for a buffer of n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Low bit index of level k inside a packed vector of w-bit fields.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/swg_mod_adder.sv
// Purpose : combinational (ptr + signed incr) mod DEPTH for a non-power-of-two buffer.
// Latency : purely combinational, no state.
// Backpr. : none; the caller decides when to register sum_o.
// Ports   : ptr_i (current pointer, < DEPTH), incr_i (signed step, |incr| < DEPTH),
//           sum_o (wrapped pointer).
module swg_mod_adder
  import swg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic [clog2_min1(DEPTH)-1:0] ptr_i,
  input  logic [WIDTH-1:0]             incr_i,
  output logic [clog2_min1(DEPTH)-1:0] sum_o
);

  localparam int AW = clog2_min1(DEPTH);
  // Two guard bits over the wider operand hold both the carry past DEPTH
  // and the sign of an underflow.
  localparam int SW = ((WIDTH > AW) ? WIDTH : AW) + 2;
  localparam logic signed [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic signed [SW-1:0] sum_s;
  logic signed [SW-1:0] fix_s;
  logic                 unused_hi;

  always_comb begin
    sum_s = $signed({{(SW-AW){1'b0}}, ptr_i}) +
            $signed({{(SW-WIDTH){incr_i[WIDTH-1]}}, incr_i});
    fix_s = sum_s;
    // One correction is enough because |incr| < DEPTH.
    if (sum_s[SW-1]) begin
      fix_s = sum_s + DEPTH_S;
    end else if (sum_s >= DEPTH_S) begin
      fix_s = sum_s - DEPTH_S;
    end
  end

  assign sum_o     = fix_s[AW-1:0];
  assign unused_hi = ^fix_s[SW-1:AW];

endmodule

// File: rtl/swg_loop_addr_gen.sv
// Purpose : N-level nested-loop read-address generator for the SWG cyclic buffer.
// Latency : first beat the cycle after start is sampled; one beat per cycle thereafter.
// Backpr. : addr_ready low holds addr/addr_valid/addr_last/frame_last stable.
// Ports   : start/busy/done frame control; cfg_valid/cfg_ready/cfg_iter/cfg_incr/cfg_tail
//           configuration load (IDLE only); addr_valid/addr_ready/addr/addr_last/frame_last
//           address stream. Level 0 is the innermost loop.
// Build   : define SWG_RUNTIME_CFG_EN to get runtime-loadable shadow configuration;
//           otherwise the DEFAULT_* parameters are the fixed loop configuration.
module swg_loop_addr_gen
  import swg_pkg::*;
#(
  parameter int NUM_LOOPS  = 5,
  parameter int CNT_WIDTH  = 16,
  parameter int INCR_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter logic [NUM_LOOPS*CNT_WIDTH-1:0]  DEFAULT_ITER = '1,
  parameter logic [NUM_LOOPS*INCR_WIDTH-1:0] DEFAULT_INCR = '0,
  parameter logic [INCR_WIDTH-1:0]           DEFAULT_TAIL = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [NUM_LOOPS*CNT_WIDTH-1:0]  cfg_iter,
  input  logic [NUM_LOOPS*INCR_WIDTH-1:0] cfg_incr,
  input  logic [INCR_WIDTH-1:0]           cfg_tail,
  output logic                            addr_valid,
  input  logic                            addr_ready,
  output logic [clog2_min1(DEPTH)-1:0]    addr,
  output logic [NUM_LOOPS-1:0]            addr_last,
  output logic                            frame_last
);

  localparam int AW = clog2_min1(DEPTH);

  ctrl_state_e                          state_q, state_d;
  logic                                 done_q, done_d;
  logic [NUM_LOOPS-1:0][CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]                        ptr_q, ptr_d, ptr_sum;

  logic [NUM_LOOPS*CNT_WIDTH-1:0]       iter_w;
  logic [NUM_LOOPS*INCR_WIDTH-1:0]      incr_w;
  logic [INCR_WIDTH-1:0]                tail_w;

  logic [CNT_WIDTH-1:0]                 iter_k;
  logic [NUM_LOOPS-1:0]                 lvl_fin;    // level k on its final iteration
  logic [NUM_LOOPS-1:0]                 below_fin;  // all levels below k final
  logic [NUM_LOOPS-1:0]                 last_run;   // levels 0..k all final
  logic                                 run_acc;
  logic [INCR_WIDTH-1:0]                step;
  logic                                 accept;
  logic                                 final_beat;

  // ---------------------------------------------------------------------------
  // Loop configuration source
  // ---------------------------------------------------------------------------
`ifdef SWG_RUNTIME_CFG_EN
  logic [NUM_LOOPS*CNT_WIDTH-1:0]  iter_q;
  logic [NUM_LOOPS*INCR_WIDTH-1:0] incr_q;
  logic [INCR_WIDTH-1:0]           tail_q;

  assign cfg_ready = (state_q == IDLE);

  // Loading on the same edge that samples start lets that frame use the new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_q <= DEFAULT_ITER;
      incr_q <= DEFAULT_INCR;
      tail_q <= DEFAULT_TAIL;
    end else if (cfg_valid && cfg_ready) begin
      iter_q <= cfg_iter;
      incr_q <= cfg_incr;
      tail_q <= cfg_tail;
    end
  end

  assign iter_w = iter_q;
  assign incr_w = incr_q;
  assign tail_w = tail_q;
`else
  logic unused_cfg;

  assign cfg_ready  = 1'b0;
  assign unused_cfg = ^{cfg_valid, cfg_iter, cfg_incr, cfg_tail};
  assign iter_w     = DEFAULT_ITER;
  assign incr_w     = DEFAULT_INCR;
  assign tail_w     = DEFAULT_TAIL;
`endif

  // ---------------------------------------------------------------------------
  // Per-level final-iteration detection
  // ---------------------------------------------------------------------------
  always_comb begin
    iter_k    = '0;
    lvl_fin   = '0;
    below_fin = '0;
    last_run  = '0;
    run_acc   = 1'b1;
    for (int k = 0; k < NUM_LOOPS; k++) begin
      iter_k = iter_w[slice_lo(k, CNT_WIDTH) +: CNT_WIDTH];
      if (iter_k == '0) begin
        iter_k = CNT_WIDTH'(1);   // a zero count behaves as a single iteration
      end
      lvl_fin[k]   = (cnt_q[k] == iter_k - CNT_WIDTH'(1));
      below_fin[k] = run_acc;
      run_acc      = run_acc & lvl_fin[k];
      last_run[k]  = run_acc;
    end
  end

  assign final_beat = last_run[NUM_LOOPS-1];
  assign busy       = (state_q == RUN);
  assign addr_valid = busy;
  assign accept     = addr_valid && addr_ready;
  assign addr       = ptr_q;
  assign addr_last  = busy ? last_run : '0;
  assign frame_last = addr_last[NUM_LOOPS-1];
  assign done       = done_q;

  // The advancing level is the lowest non-final one; on the final beat the
  // frame-to-frame tail step is used instead.
  always_comb begin
    step = tail_w;
    if (!final_beat) begin
      for (int k = 0; k < NUM_LOOPS; k++) begin
        if (below_fin[k] && !lvl_fin[k]) begin
          step = incr_w[slice_lo(k, INCR_WIDTH) +: INCR_WIDTH];
        end
      end
    end
  end

  swg_mod_adder #(
    .WIDTH (INCR_WIDTH),
    .DEPTH (DEPTH)
  ) u_mod_adder (
    .ptr_i  (ptr_q),
    .incr_i (step),
    .sum_o  (ptr_sum)
  );

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          ptr_d = ptr_sum;
          // Levels below the advancing one wrap to 0, the advancing one counts
          // up, higher ones hold. On the final beat every level wraps.
          for (int k = 0; k < NUM_LOOPS; k++) begin
            if (below_fin[k]) begin
              cnt_d[k] = lvl_fin[k] ? '0 : cnt_q[k] + CNT_WIDTH'(1);
            end
          end
          if (final_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_swg_loop_addr_gen.sv
// Directed bench for swg_loop_addr_gen: two loop levels, DEPTH=8,
// defaults iter={outer 2, inner 3}, incr={+2,+1}, tail=-7.
module tb_swg_loop_addr_gen;

`ifdef SWG_RUNTIME_CFG_EN
  localparam logic [31:0] CFG_RDY = 32'd1;
`else
  localparam logic [31:0] CFG_RDY = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_iter = '0;
  logic [31:0] cfg_incr = '0;
  logic [15:0] cfg_tail = '0;
  logic        addr_valid;
  logic        addr_ready = 1'b1;
  logic [2:0]  addr;
  logic [1:0]  addr_last;
  logic        frame_last;

  int vec_cnt = 0;
  int err_cnt = 0;
  int ea [8];
  int el [8];

  always #5 clk = ~clk;

  swg_loop_addr_gen #(
    .NUM_LOOPS    (2),
    .CNT_WIDTH    (16),
    .INCR_WIDTH   (16),
    .DEPTH        (8),
    .DEFAULT_ITER ({16'd2, 16'd3}),
    .DEFAULT_INCR ({16'h0002, 16'h0001}),
    .DEFAULT_TAIL (16'hFFF9)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_iter   (cfg_iter),
    .cfg_incr   (cfg_incr),
    .cfg_tail   (cfg_tail),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr       (addr),
    .addr_last  (addr_last),
    .frame_last (frame_last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge. Raises start, then checks n beats against ea/el,
  // optionally with random addr_ready. Every cycle, stalled or not, must show
  // the expected beat. With full=1 it also checks the done pulse.
  task automatic run_frame(input int n, input bit rnd, input bit full);
    int acc = 0;
    int cyc = 0;
    bit r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (acc < n && cyc < 300) begin
      cyc++;
      r = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      addr_ready = r;
      chk("addr_valid", addr_valid, 1);
      chk("addr", addr, ea[acc]);
      chk("addr_last", addr_last, el[acc]);
      chk("frame_last", frame_last, (el[acc] >> 1) & 1);
      chk("busy_run", busy, 1);
      chk("cfg_ready_run", cfg_ready, 0);
      chk("done_run", done, 0);
      @(negedge clk);
      if (r) acc++;
    end
    if (acc < n) chk("beat_timeout", acc, n);
    addr_ready = 1'b1;
    if (full) begin
      chk("done_pulse", done, 1);
      chk("addr_valid_idle", addr_valid, 0);
      chk("busy_idle", busy, 0);
      chk("cfg_ready_idle", cfg_ready, CFG_RDY);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_addr_valid", addr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_ready", cfg_ready, CFG_RDY);
    chk("rst_addr_last", addr_last, 0);
    chk("rst_frame_last", frame_last, 0);
    chk("rst_addr", addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame A: 0,1,2 | +2 | 4,5,6, then tail -7 -> 7
    ea = '{0, 1, 2, 4, 5, 6, 0, 0};
    el = '{0, 0, 1, 0, 0, 3, 0, 0};
    run_frame(6, 1'b0, 1'b1);

`ifndef SWG_RUNTIME_CFG_EN
    // Config port must be ignored in the fixed build.
    cfg_valid = 1'b1;
    cfg_iter  = {16'd1, 16'd1};
    cfg_incr  = {16'h0003, 16'h0003};
    cfg_tail  = 16'h0001;
`endif

    // Frame B started in the done cycle: wraps 7 -> 0; tail 5-7 -> 6
    ea = '{7, 0, 1, 3, 4, 5, 0, 0};
    run_frame(6, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("idle_cfg_ready", cfg_ready, CFG_RDY);
    chk("idle_addr_valid", addr_valid, 0);

    // Frame C with random backpressure: 6,7,0,2,3,4; tail 4-7 -> 5
    ea = '{6, 7, 0, 2, 3, 4, 0, 0};
    run_frame(6, 1'b1, 1'b1);
    cfg_valid = 1'b0;
    @(negedge clk);

    // Frame D aborted by reset after the third beat
    ea = '{5, 6, 7, 0, 0, 0, 0, 0};
    run_frame(3, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_addr_valid", addr_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cfg_ready", cfg_ready, CFG_RDY);
    chk("arst_frame_last", frame_last, 0);
    @(negedge clk);
    chk("arst_no_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_done", done, 0);

    // Restart from pointer 0
    ea = '{0, 1, 2, 4, 5, 6, 0, 0};
    run_frame(6, 1'b0, 1'b1);

`ifdef SWG_RUNTIME_CFG_EN
    // Load iter={2,3}, incr={-4,+1}, tail=+3 from a fresh pointer of 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cfg_valid = 1'b1;
    cfg_iter  = {16'd2, 16'd3};
    cfg_incr  = {16'hFFFC, 16'h0001};
    cfg_tail  = 16'h0003;
    @(negedge clk);
    cfg_valid = 1'b0;
    ea = '{0, 1, 2, 6, 7, 0, 0, 0};
    run_frame(6, 1'b0, 1'b1);

    // Config and start on the same edge: single beat at pointer 3
    cfg_valid = 1'b1;
    cfg_iter  = {16'd1, 16'd0};
    cfg_incr  = '0;
    cfg_tail  = '0;
    ea = '{3, 0, 0, 0, 0, 0, 0, 0};
    el = '{3, 0, 0, 0, 0, 0, 0, 0};
    run_frame(1, 1'b0, 1'b1);
    cfg_valid = 1'b0;
    @(negedge clk);
    run_frame(1, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/swg_loop_addr_gen.md
# swg_loop_addr_gen

Runtime-configurable N-level nested-loop read-address generator for the sliding-window generator's cyclic buffer. It is the successor to the fixed five-level SWG loop controller: the loop depth is a parameter, and loop bounds and increments can be reloaded between frames. It emits absolute buffer read addresses over a valid/ready stream, with per-level wrap flags. It sits between the SWG input-side write logic and the addressable cyclic buffer's read port.

## Interface
- NUM_LOOPS, 5, number of nested loop levels (2..8); level 0 is innermost
- CNT_WIDTH, 16, width of each iteration count
- INCR_WIDTH, 16, width of each signed address increment
- DEPTH, 64, cyclic buffer depth; need not be a power of two
- DEFAULT_ITER, all 1s, packed NUM_LOOPS*CNT_WIDTH; iteration counts after reset
- DEFAULT_INCR, all 0, packed NUM_LOOPS*INCR_WIDTH signed; per-level increments after reset
- DEFAULT_TAIL, 0, signed frame-to-frame increment after reset
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- start  in  1  frame start request; honoured only in IDLE
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the final beat of a frame is accepted
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted; high only in IDLE
- cfg_iter  in  NUM_LOOPS*CNT_WIDTH  iteration counts; 0 is treated as 1
- cfg_incr  in  NUM_LOOPS*INCR_WIDTH  signed increment applied when level k advances
- cfg_tail  in  INCR_WIDTH  signed increment applied after the last beat of a frame
- addr_valid  out  1  address beat valid
- addr_ready  in  1  downstream accepts the beat
- addr  out  $clog2(DEPTH)  absolute read address
- addr_last  out  NUM_LOOPS  bit k: levels 0..k are all on their final iteration
- frame_last  out  1  equals addr_last[NUM_LOOPS-1]

## Operation
- States (enum ctrl_state_e): IDLE, RUN.
- IDLE → RUN when start=1 is sampled. Loop counters are cleared to 0 on that edge.
- RUN → IDLE when the beat with frame_last=1 is accepted. done pulses in the following cycle.
- A beat is accepted when addr_valid && addr_ready.
- On an accepted, non-final beat:
  - k = lowest level whose counter is below iter[k]-1.
  - Counters 0..k-1 clear; counter k increments.
  - Pointer becomes (ptr + incr[k]) mod DEPTH.
- On the final beat, the pointer becomes (ptr + tail) mod DEPTH. The pointer persists across frames.
- Modular add: computed at INCR_WIDTH+2 signed width. If the sum is ≥ DEPTH, subtract DEPTH; if it is < 0, add DEPTH. Requirement: |incr|, |tail| < DEPTH. Other values are undefined behaviour; the bench must not drive them.
- Outputs: addr = ptr; addr_valid = (state==RUN). addr_last is computed from the current counters.
- Config: when cfg_valid && cfg_ready, cfg_iter/cfg_incr/cfg_tail are loaded into shadow registers. The pointer is unaffected.
- Config and start sampled on the same edge: the new config governs that frame.
- start during RUN is ignored and not queued.

## Timing
- Reset values: state IDLE, ptr 0, counters 0, addr_valid 0, busy 0, done 0, cfg_ready 1, addr_last 0, frame_last 0. Config registers take DEFAULT_*.
- First beat: addr_valid rises the cycle after start is sampled; addr = ptr at that point.
- Throughput: one beat per cycle while addr_ready=1.
- addr_ready=0: addr, addr_valid, addr_last and frame_last are held stable.
- Frame of 1 beat (all iterations 1): the first beat has frame_last=1.
- done is high the cycle after the final acceptance; start may be sampled in that same cycle, giving a 1-cycle bubble between frames.
- rst_n asserted mid-frame: immediate return to reset values; no done pulse.

## Configuration
- SWG_RUNTIME_CFG_EN defined: shadow configuration registers and the cfg handshake are implemented.
- Not defined:
  - cfg_ready is tied to 0 and cfg_* inputs are ignored.
  - iter/incr/tail are the constant DEFAULT_* parameters; no config registers are synthesised.

## Structure
- Package swg_pkg holds:
  - ctrl_state_e;
  - function clog2_min1 (address width, minimum 1);
  - localparam-style helpers to slice packed cfg vectors.
- Sub-module swg_mod_adder (parameters WIDTH, DEPTH): combinational modular add of a pointer and a signed increment. It is instantiated once; the increment is muxed between incr[k] and tail.

## Test plan
- Config NUM_LOOPS=2, DEPTH=8, iter={inner 3, outer 2}, incr={+1,+2}, tail=+3, addr_ready=1, start → addr 0,1,2,4,5,6.
  - addr_last[0]=1 on 2 and 6; frame_last only on 6.
  - done pulses the next cycle; next frame starts at addr 1.
- Same config with incr outer=-4 → addr 0,1,2,6,7,0. Checks negative and positive wrap.
- Random addr_ready toggling (~50%) → sequence identical to the first case; addr is stable on every stalled cycle.
- cfg_valid and start in the same cycle with iter={1,1} → a single beat at the current pointer with frame_last=1; cfg_ready=0 throughout RUN.
- rst_n low after the 3rd beat → addr_valid=0 immediately, no done pulse, cfg_ready=1; a restart begins at addr 0.
- Build without SWG_RUNTIME_CFG_EN, DEFAULT_ITER={2,2}, DEFAULT_INCR={+1,+1} → addr 0,1,2,3; cfg_ready remains 0.
